// File: rtl/gx_rst_pkg.sv
// Shared types and timing defaults for the GX standard-PCS reset sequencer.
package gx_rst_pkg;

    typedef enum logic [1:0] {TX_ANA, TX_WAIT, TX_DIG, TX_RDY} tx_state_t;
    typedef enum logic [2:0] {RX_ANA, RX_WAIT_CAL, RX_WAIT_LTD, RX_DIG, RX_RDY} rx_state_t;

    localparam int unsigned SYNC_STAGES = 2;

    localparam int unsigned DEF_NUM_CH        = 5;
    localparam int unsigned DEF_T_ANALOG      = 70;
    localparam int unsigned DEF_T_DIGITAL     = 20;
    localparam int unsigned DEF_T_LTD         = 400;
    localparam int unsigned DEF_T_LTD_TIMEOUT = 100000;
    localparam int unsigned DEF_CNT_W         = 17;

endpackage

// File: rtl/gx_rx_rst_fsm.sv
// One RX channel of the GX reset sequencer: input synchronisers, timers and the channel FSM.
module gx_rx_rst_fsm
    import gx_rst_pkg::*;
#(
    parameter int unsigned T_ANALOG      = DEF_T_ANALOG,
    parameter int unsigned T_DIGITAL     = DEF_T_DIGITAL,
    parameter int unsigned T_LTD         = DEF_T_LTD,
    parameter int unsigned T_LTD_TIMEOUT = DEF_T_LTD_TIMEOUT,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic cal_busy,
    input  logic lockedtodata,
    input  logic reset_req,
    output logic analogreset,
    output logic digitalreset,
    output logic ready
);

    localparam logic [CNT_W-1:0] ANA_LAST   = CNT_W'(T_ANALOG - 1);
    localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(T_DIGITAL - 1);
    localparam logic [CNT_W-1:0] LTD_STABLE = CNT_W'(T_LTD);
    localparam logic [CNT_W-1:0] LTD_LIMIT  = CNT_W'(T_LTD_TIMEOUT);

    rx_state_t              state_q;
    logic [SYNC_STAGES-1:0] cal_sync_q, ltd_sync_q;
    logic                   cal_s, ltd_s;
    logic [CNT_W-1:0]       cnt_q, stable_q, cnt_inc, stable_inc;
    logic                   ana_q, dig_q, ready_q;

    assign cal_s = cal_sync_q[SYNC_STAGES-1];
    assign ltd_s = ltd_sync_q[SYNC_STAGES-1];

    // Saturating increments; the stable count restarts whenever lock drops.
    always_comb begin
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        stable_inc = '0;
        if (ltd_s) begin
            stable_inc = (stable_q == '1) ? stable_q : stable_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cal_sync_q <= '0;
            ltd_sync_q <= '0;
            state_q    <= RX_ANA;
            cnt_q      <= '0;
            stable_q   <= '0;
            ana_q      <= 1'b1;
            dig_q      <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            cal_sync_q <= {cal_sync_q[SYNC_STAGES-2:0], cal_busy};
            ltd_sync_q <= {ltd_sync_q[SYNC_STAGES-2:0], lockedtodata};
            if (reset_req) begin
                state_q  <= RX_ANA;
                cnt_q    <= '0;
                stable_q <= '0;
                ana_q    <= 1'b1;
                dig_q    <= 1'b1;
                ready_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    RX_ANA: begin
                        if (cnt_q == ANA_LAST) begin
                            state_q <= RX_WAIT_CAL;
                            ana_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    RX_WAIT_CAL: begin
                        if (!cal_s) begin
                            state_q  <= RX_WAIT_LTD;
                            cnt_q    <= '0;
                            stable_q <= '0;
                        end
                    end
                    RX_WAIT_LTD: begin
                        // Timeout is checked first so it wins a same-cycle tie.
                        if (cnt_inc >= LTD_LIMIT) begin
                            state_q <= RX_ANA;
                            cnt_q   <= '0;
                            ana_q   <= 1'b1;
                        end else if (stable_inc >= LTD_STABLE) begin
                            state_q <= RX_DIG;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q    <= cnt_inc;
                            stable_q <= stable_inc;
                        end
                    end
                    RX_DIG: begin
                        if (!ltd_s) begin
                            state_q  <= RX_WAIT_LTD;
                            cnt_q    <= '0;
                            stable_q <= '0;
                        end else if (cnt_q == DIG_LAST) begin
                            state_q <= RX_RDY;
                            dig_q   <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    RX_RDY: begin
                        if (!ltd_s) begin
                            state_q  <= RX_WAIT_LTD;
                            cnt_q    <= '0;
                            stable_q <= '0;
                            dig_q    <= 1'b1;
                            ready_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= RX_ANA;
                        cnt_q   <= '0;
                        ana_q   <= 1'b1;
                        dig_q   <= 1'b1;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign analogreset  = ana_q;
    assign digitalreset = dig_q;
    assign ready        = ready_q;

endmodule

// File: rtl/gx_std_xn_rst_ctrl.sv
// Reset sequencer for an N-channel GX bank: one bonded TX FSM plus an independent RX FSM per channel.
module gx_std_xn_rst_ctrl
    import gx_rst_pkg::*;
#(
    parameter int unsigned NUM_CH        = DEF_NUM_CH,
    parameter int unsigned T_ANALOG      = DEF_T_ANALOG,
    parameter int unsigned T_DIGITAL     = DEF_T_DIGITAL,
    parameter int unsigned T_LTD         = DEF_T_LTD,
    parameter int unsigned T_LTD_TIMEOUT = DEF_T_LTD_TIMEOUT,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic              reconfig_clk,
    input  logic              reconfig_reset,
    input  logic              tx_pll_locked,
    input  logic [NUM_CH-1:0] tx_cal_busy,
    input  logic [NUM_CH-1:0] rx_cal_busy,
    input  logic [NUM_CH-1:0] rx_is_lockedtodata,
    input  logic              tx_reset_req,
    input  logic [NUM_CH-1:0] rx_reset_req,
    output logic [NUM_CH-1:0] tx_analogreset,
    output logic [NUM_CH-1:0] tx_digitalreset,
    output logic [NUM_CH-1:0] rx_analogreset,
    output logic [NUM_CH-1:0] rx_digitalreset,
    output logic              tx_ready,
    output logic [NUM_CH-1:0] rx_ready
);

    localparam logic [CNT_W-1:0] ANA_LAST = CNT_W'(T_ANALOG - 1);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(T_DIGITAL - 1);

    tx_state_t                          tx_state_q;
    logic [SYNC_STAGES-1:0]             pll_sync_q;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] cal_sync_q;
    logic                               pll_s, tx_ok;
    logic [CNT_W-1:0]                   tx_cnt_q;
    logic                               tx_ana_q, tx_dig_q, tx_ready_q;

    assign pll_s = pll_sync_q[SYNC_STAGES-1];
    assign tx_ok = pll_s && !(|cal_sync_q[SYNC_STAGES-1]);

    always_ff @(posedge reconfig_clk) begin
        if (reconfig_reset) begin
            pll_sync_q <= '0;
            cal_sync_q <= '0;
            tx_state_q <= TX_ANA;
            tx_cnt_q   <= '0;
            tx_ana_q   <= 1'b1;
            tx_dig_q   <= 1'b1;
            tx_ready_q <= 1'b0;
        end else begin
            pll_sync_q <= {pll_sync_q[SYNC_STAGES-2:0], tx_pll_locked};
            cal_sync_q <= {cal_sync_q[SYNC_STAGES-2:0], tx_cal_busy};
            if (tx_reset_req) begin
                // Held request keeps the counter at zero, so release restarts the full hold.
                tx_state_q <= TX_ANA;
                tx_cnt_q   <= '0;
                tx_ana_q   <= 1'b1;
                tx_dig_q   <= 1'b1;
                tx_ready_q <= 1'b0;
            end else begin
                unique case (tx_state_q)
                    TX_ANA: begin
                        if (tx_cnt_q == ANA_LAST) begin
                            tx_state_q <= TX_WAIT;
                            tx_ana_q   <= 1'b0;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                        end
                    end
                    TX_WAIT: begin
                        if (tx_ok) begin
                            tx_state_q <= TX_DIG;
                            tx_cnt_q   <= '0;
                        end
                    end
                    TX_DIG: begin
                        if (!tx_ok) begin
                            tx_state_q <= TX_WAIT;
                        end else if (tx_cnt_q == DIG_LAST) begin
                            tx_state_q <= TX_RDY;
                            tx_dig_q   <= 1'b0;
                            tx_ready_q <= 1'b1;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                        end
                    end
                    TX_RDY: begin
                        if (!pll_s) begin
                            tx_state_q <= TX_WAIT;
                            tx_dig_q   <= 1'b1;
                            tx_ready_q <= 1'b0;
                        end
                    end
                    default: begin
                        tx_state_q <= TX_ANA;
                        tx_cnt_q   <= '0;
                        tx_ana_q   <= 1'b1;
                        tx_dig_q   <= 1'b1;
                        tx_ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_analogreset  = {NUM_CH{tx_ana_q}};
    assign tx_digitalreset = {NUM_CH{tx_dig_q}};
    assign tx_ready        = tx_ready_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_rx
        gx_rx_rst_fsm #(
            .T_ANALOG      (T_ANALOG),
            .T_DIGITAL     (T_DIGITAL),
            .T_LTD         (T_LTD),
            .T_LTD_TIMEOUT (T_LTD_TIMEOUT),
            .CNT_W         (CNT_W)
        ) u_rx_fsm (
            .clk          (reconfig_clk),
            .reset        (reconfig_reset),
            .cal_busy     (rx_cal_busy[i]),
            .lockedtodata (rx_is_lockedtodata[i]),
            .reset_req    (rx_reset_req[i]),
            .analogreset  (rx_analogreset[i]),
            .digitalreset (rx_digitalreset[i]),
            .ready        (rx_ready[i])
        );
    end

endmodule
